// File: rtl/fp_stream_accumulator.sv
// FP32 stream accumulator: sums valid/ready operand groups delimited by in_last.
// Running sum loops through a combinational fpAdder32 (RNE, IEEE specials).
module fp_stream_accumulator #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_sub,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    typedef enum logic {IDLE, ACCUM} state_t;

    function automatic logic [31:0] fp_add(
        input logic [31:0] a,
        input logic [31:0] b_in,
        input logic        sub
    );
        logic [31:0] b, x, y, res;
        logic        sx, sy, sr, nan_a, nan_b, inf_a, inf_b;
        logic [9:0]  ex, ey, d, e, sh, ef;
        logic [26:0] mx, my, mys, mask, m;
        logic [27:0] r;
        logic [4:0]  lz;
        logic [24:0] mr;
        b = {b_in[31] ^ sub, b_in[30:0]};
        nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        inf_a = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        inf_b = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        sx = x[31];
        sy = y[31];
        ex = (x[30:23] == 8'd0) ? 10'd1 : {2'b00, x[30:23]};
        ey = (y[30:23] == 8'd0) ? 10'd1 : {2'b00, y[30:23]};
        mx = {x[30:23] != 8'd0, x[22:0], 3'b000};
        my = {y[30:23] != 8'd0, y[22:0], 3'b000};
        d  = ex - ey;
        mask = 27'd0;
        if (d >= 10'd27) begin
            mys = {26'd0, |my};
        end else begin
            mask = (27'd1 << d[4:0]) - 27'd1;
            mys  = (my >> d[4:0]) | {26'd0, |(my & mask)};
        end
        if (sx ^ sy)
            r = {1'b0, mx} - {1'b0, mys};
        else
            r = {1'b0, mx} + {1'b0, mys};
        lz = 5'd27;
        for (int i = 0; i < 27; i++)
            if (r[i]) lz = 5'(26 - i);
        sh = 10'd0;
        if (r[27]) begin
            m = r[27:1] | {26'd0, r[0]};
            e = ex + 10'd1;
        end else begin
            // never normalise below the minimum exponent: denormals stay denormal
            sh = ({5'd0, lz} < ex - 10'd1) ? {5'd0, lz} : ex - 10'd1;
            m  = r[26:0] << sh;
            e  = ex - sh;
        end
        mr = {1'b0, m[26:3]} + {24'd0, m[2] & ((|m[1:0]) | m[3])};
        ef = mr[24] ? e + 10'd1 : (mr[23] ? e : 10'd0);
        sr = (mr == 25'd0) ? (sx & sy) : sx;
        if (nan_a || nan_b)
            res = 32'h7FC0_0000;
        else if (inf_a && inf_b && (a[31] != b[31]))
            res = 32'h7FC0_0000;
        else if (inf_a)
            res = a;
        else if (inf_b)
            res = b;
        else if (ef >= 10'd255)
            res = {sr, 8'hFF, 23'd0};
        else
            res = {sr, ef[7:0], mr[22:0]};
        return res;
    endfunction

    state_t           state;
    logic [31:0]      acc;
    logic [CNT_W-1:0] cnt;
    logic             sat;

    logic             accept;
    logic [31:0]      first_val;
    logic [31:0]      sum;
    logic             cnt_max;
    logic [CNT_W-1:0] cnt_nxt;
    logic             sat_nxt;

    assign in_ready  = ~out_valid | out_ready;
    assign accept    = in_valid & in_ready;
    assign first_val = {in_data[31] ^ in_sub, in_data[30:0]};
    assign sum       = fp_add(acc, in_data, in_sub);
    assign cnt_max   = &cnt;
    assign cnt_nxt   = cnt_max ? cnt : cnt + 1'b1;
    assign sat_nxt   = sat | cnt_max;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= 32'd0;
            cnt       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (accept) begin
                unique case (state)
                    IDLE: begin
                        if (in_last) begin
                            out_valid <= 1'b1;
                            out_data  <= first_val;
                            out_count <= CNT_W'(1);
                            out_sat   <= 1'b0;
                        end else begin
                            state <= ACCUM;
                            acc   <= first_val;
                            cnt   <= CNT_W'(1);
                            sat   <= 1'b0;
                        end
                    end
                    ACCUM: begin
                        if (in_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b1;
                            out_data  <= sum;
                            out_count <= cnt_nxt;
                            out_sat   <= sat_nxt;
                        end else begin
                            acc <= sum;
                            cnt <= cnt_nxt;
                            sat <= sat_nxt;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fp_stream_accumulator.sv
// Scoreboard bench for fp_stream_accumulator (CNT_W=2 to reach saturation).
// Expected sums come from exact constants or integer arithmetic.
module tb_fp_stream_accumulator;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          in_sub;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [CW-1:0] out_count;
    logic          out_sat;

    typedef struct packed {
        logic [31:0]   d;
        logic [CW-1:0] c;
        logic          s;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    bit   ready_mode  = 1'b0;
    bit   ready_force = 1'b1;

    fp_stream_accumulator #(.CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] d, input int c,
                                input logic s);
        exp_t e;
        e.d = d;
        e.c = CW'(c);
        e.s = s;
        return e;
    endfunction

    function automatic logic [31:0] int_to_fp(input int x);
        int          a;
        int          msb;
        logic [31:0] m;
        logic [7:0]  e;
        if (x == 0) return 32'd0;
        a = (x < 0) ? -x : x;
        msb = 0;
        for (int i = 0; i < 31; i++)
            if (a[i]) msb = i;
        m = 32'(a) << (23 - msb);
        e = 8'(127 + msb);
        return {(x < 0), e, m[22:0]};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] d, input logic s,
                        input logic l, input exp_t e);
        bit ok;
        int t;
        ok = 1'b0;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = s;
        in_last  = l;
        while (!ok && t < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!ok)
            chk("send_timeout", {31'd0, ok}, 32'd1);
        else if (l)
            sb.push_back(e);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                exp_t e;
                if (sb.size() == 0) begin
                    chk("spurious", 32'(out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_count", 32'(out_count), 32'(e.c));
                    chk("out_sat", 32'(out_sat), 32'(e.s));
                end
            end
        end
    end

    initial begin
        int n;
        int sum;
        int v;
        bit s;
        int t;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 32'd0;
        in_sub   = 1'b0;
        in_last  = 1'b0;
        idle(3);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_sat", 32'(out_sat), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        idle(1);

        send(32'h3F80_0000, 1'b0, 1'b0, '0);
        send(32'h4000_0000, 1'b0, 1'b0, '0);
        send(32'h4040_0000, 1'b0, 1'b1, mk(32'h40C0_0000, 3, 1'b0));
        idle(2);

        send(32'h4000_0000, 1'b1, 1'b1, mk(32'hC000_0000, 1, 1'b0));
        chk("lat1_valid", 32'(out_valid), 32'd1);
        idle(2);

        ready_force = 1'b0;
        idle(2);
        send(32'h4080_0000, 1'b0, 1'b1, mk(32'h4080_0000, 1, 1'b0));
        repeat (10) begin
            @(negedge clk);
            chk("stall_ready", 32'(in_ready), 32'd0);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", out_data, 32'h4080_0000);
        end
        @(posedge clk);
        #1;
        ready_force = 1'b1;
        @(negedge clk);
        chk("release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("release_valid", 32'(out_valid), 32'd0);
        idle(1);

        send(32'h3F80_0000, 1'b0, 1'b1, mk(32'h3F80_0000, 1, 1'b0));
        chk("b2b_v1", 32'(out_valid), 32'd1);
        send(32'h4000_0000, 1'b0, 1'b1, mk(32'h4000_0000, 1, 1'b0));
        chk("b2b_v2", 32'(out_valid), 32'd1);
        idle(1);
        chk("b2b_end", 32'(out_valid), 32'd0);
        idle(1);

        send(32'h3F80_0000, 1'b0, 1'b0, '0);
        send(32'h3F80_0000, 1'b0, 1'b0, '0);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        send(32'h4040_0000, 1'b0, 1'b1, mk(32'h4040_0000, 1, 1'b0));
        idle(2);

        ready_force = 1'b0;
        idle(2);
        send(32'h40E0_0000, 1'b0, 1'b1, '0);
        void'(sb.pop_back());
        reset = 1'b1;
        idle(1);
        chk("pendrst_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        ready_force = 1'b1;
        idle(2);

        repeat (4) send(32'h3F80_0000, 1'b0, 1'b0, '0);
        send(32'h3F80_0000, 1'b0, 1'b1, mk(32'h40A0_0000, 3, 1'b1));

        send(32'h3F80_0000, 1'b0, 1'b0, '0);
        send(32'h3380_0000, 1'b0, 1'b1, mk(32'h3F80_0000, 2, 1'b0));
        send(32'h3F80_0001, 1'b0, 1'b0, '0);
        send(32'h3380_0000, 1'b0, 1'b1, mk(32'h3F80_0002, 2, 1'b0));
        send(32'h7F80_0000, 1'b0, 1'b0, '0);
        send(32'h7F80_0000, 1'b1, 1'b1, mk(32'h7FC0_0000, 2, 1'b0));
        send(32'h4040_0000, 1'b0, 1'b0, '0);
        send(32'h4040_0000, 1'b1, 1'b1, mk(32'h0000_0000, 2, 1'b0));
        idle(2);

        ready_mode = 1'b1;
        for (int g = 0; g < 25; g++) begin
            n = $urandom_range(1, 6);
            sum = 0;
            for (int k = 0; k < n; k++) begin
                v = $urandom_range(1, 50);
                if ($urandom_range(0, 1) == 1) v = -v;
                s = 1'($urandom_range(0, 1));
                sum += s ? -v : v;
                send(int_to_fp(v), s, (k == n - 1),
                     mk(int_to_fp(sum), (n > 3) ? 3 : n, (n > 3)));
            end
        end
        ready_mode = 1'b0;
        ready_force = 1'b1;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            idle(1);
            t++;
        end
        chk("drain", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
